// File: rtl/factorial_pkg.sv
// factorial_pkg: select codes, state encoding and defaults shared by the factorial controller and datapath.
package factorial_pkg;
    localparam int MAX_N_DEF = 12;
    localparam int CNT_W_DEF = 6;
    localparam logic [1:0] WA_HOLD = 2'b00;
    localparam logic [1:0] WA_MUL  = 2'b01;
    localparam logic [1:0] WA_ONE  = 2'b10;
    localparam logic [1:0] WB_LOAD = 2'b00;
    localparam logic [1:0] WB_DEC  = 2'b01;
    localparam logic [1:0] WB_HOLD = 2'b10;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
endpackage

// File: rtl/factorial_ctrl_if.sv
// factorial_ctrl_if: select/flag link between the factorial controller (master) and datapath (slave).
interface factorial_ctrl_if;
    logic [31:0] N;
    logic [1:0]  waSel;
    logic [1:0]  wbSel;
    logic        z;
    logic [31:0] a;
    modport master (output N, waSel, wbSel, input z, a);
    modport slave (input N, waSel, wbSel, output z, a);
endinterface

// File: rtl/factorial_ctrl.sv
// factorial_ctrl: start/done sequencer for the factorial datapath with operand range check and iteration watchdog.
module factorial_ctrl
    import factorial_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       n_in,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       result,
    factorial_ctrl_if.master  dp
);
    localparam logic [31:0]      N_LIMIT  = 32'(MAX_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_N + 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             expired;
    logic             step;
    assign expired = cnt == CNT_LAST;
    // Only the CHECK selects look at z; everything else is a pure function of state.
    assign step     = state == CHECK && !dp.z && !expired;
    assign dp.waSel = state == LOAD ? WA_ONE : step ? WA_MUL : WA_HOLD;
    assign dp.wbSel = state == LOAD ? WB_LOAD : step ? WB_DEC : WB_HOLD;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            dp.N   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dp.N  <= n_in;
                    cnt   <= '0;
                    ready <= 1'b0;
                    if (n_in > N_LIMIT) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        err   <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: state <= CHECK;
                CHECK: if (dp.z) begin
                    result <= dp.a;
                    done   <= 1'b1;
                    state  <= DONE;
                end else if (expired) begin
                    result <= '0;
                    err    <= 1'b1;
                    done   <= 1'b1;
                    state  <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_factorial_ctrl.sv
// tb_factorial_ctrl: directed and random factorial requests against a behavioural datapath and reference model.
module tb_factorial_ctrl;
    import factorial_pkg::*;
    localparam int MAX_N = 12;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n_in = '0;
    logic        ready, done, err;
    logic [31:0] result;
    logic        force_z0 = 1'b0;
    logic [31:0] a_q = 32'hdead_beef;
    logic [31:0] b_q = 32'd7;
    int          n_checks = 0;
    int          n_fails = 0;

    factorial_ctrl_if dif ();

    factorial_ctrl #(.MAX_N(MAX_N), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n_in   (n_in),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .result (result),
        .dp     (dif)
    );

    always #5 clk = ~clk;

    // Unreset datapath, as in the real system
    always_ff @(posedge clk) begin
        a_q <= dif.waSel == WA_MUL ? a_q * b_q : dif.waSel == WA_ONE ? 32'd1 : a_q;
        b_q <= dif.wbSel == WB_LOAD ? dif.N : dif.wbSel == WB_DEC ? b_q - 32'd1 : b_q;
    end
    assign dif.z = !force_z0 && b_q == 32'd0;
    assign dif.a = a_q;

    function automatic logic [31:0] fact(int n);
        logic [31:0] f = 32'd1;
        for (int i = 2; i <= n; i++) f = f * 32'(i);
        return f;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic run(logic [31:0] n, bit fz, bit noise);
        bit          legal = n <= 32'(MAX_N);
        int          exp_done = !legal ? 1 : fz ? MAX_N + 4 : int'(n) + 3;
        int          muls = !legal ? 0 : fz ? MAX_N + 1 : int'(n);
        logic [31:0] exp_res = (!legal || fz) ? 32'd0 : fact(int'(n));
        logic [1:0]  exp_wa, exp_wb;
        bit          seen = 0;
        chk("ready_idle", 32'(ready), 32'd1);
        force_z0 = fz;
        start = 1'b1;
        n_in = n;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            start = noise ? 1'($urandom) : 1'b0;
            n_in = $urandom;
            exp_wa = legal && c == 1 ? WA_ONE : (c >= 2 && c <= muls + 1) ? WA_MUL : WA_HOLD;
            exp_wb = legal && c == 1 ? WB_LOAD : (c >= 2 && c <= muls + 1) ? WB_DEC : WB_HOLD;
            chk("done_timing", 32'(done), 32'(c == exp_done));
            chk("ready_busy", 32'(ready), 32'd0);
            chk("wa_sel", 32'(dif.waSel), 32'(exp_wa));
            chk("wb_sel", 32'(dif.wbSel), 32'(exp_wb));
            if (done) begin
                seen = 1;
                start = 1'b0;
                chk("err", 32'(err), 32'(!legal || fz));
                chk("result", result, exp_res);
            end
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'd1);
        @(negedge clk);
        chk("ready_after", 32'(ready), 32'd1);
        chk("done_after", 32'(done), 32'd0);
        chk("result_held", result, exp_res);
        force_z0 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wa", 32'(dif.waSel), 32'(WA_HOLD));
        chk("rst_wb", 32'(dif.wbSel), 32'(WB_HOLD));
        chk("rst_n", dif.N, 32'd0);
        run(32'd5, 0, 0);
        run(32'd0, 0, 0);
        run(32'd12, 0, 0);
        run(32'd13, 0, 0);
        run(32'hffff_ffff, 0, 1);
        run(32'd3, 1, 0);
        chk("n_reg", dif.N, 32'd3);
        start = 1'b1;
        n_in = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_wa", 32'(dif.waSel), 32'(WA_HOLD));
        chk("mid_rst_wb", 32'(dif.wbSel), 32'(WB_HOLD));
        rst = 1'b0;
        run(32'd4, 0, 0);
        for (int i = 0; i < 10; i++) run(32'($urandom_range(0, 15)), 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
